// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory (combinational read, clocked write) between the CPU
// load/store port (requester 0) and the loader/debug port (requester 1).
//
// At most one access is granted per cycle:
//   - IDLE  : a lone requester wins; on a tie the requester that was NOT
//             granted most recently wins (round robin through `last`).
//   - LOCKn : only requester n can be granted. The lock is taken by a transfer
//             with lock = 1 and dropped by a transfer with lock = 0.
// The granted requester's fields drive the memory in the same cycle. The
// response (read data, or 0 for a write ack) is registered and presented with
// a one-cycle rsp_valid pulse in the following cycle.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   rN_valid / rN_ready       request handshake (ready is the grant, comb.)
//   rN_addr / rN_we / rN_wdata / rN_lock   request fields
//   rN_rsp_valid / rN_rsp_rdata            registered response
//   mem_addr / mem_we / mem_wdata          to memory (zeros when no grant)
//   mem_rdata                 from memory, combinational read of mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DWIDTH-1:0] r0_addr,
  input  logic              r0_we,
  input  logic [DWIDTH-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_rsp_valid,
  output logic [DWIDTH-1:0] r0_rsp_rdata,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DWIDTH-1:0] r1_addr,
  input  logic              r1_we,
  input  logic [DWIDTH-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_rsp_valid,
  output logic [DWIDTH-1:0] r1_rsp_rdata,

  output logic [DWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   last;     // most recently granted requester
  logic   grant0;
  logic   grant1;

  // Grant decision: depends only on valid and arbitration state, never on
  // lock/we/addr, so requesters cannot build a combinational loop via ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          // Tie: favour the requester that was not served last.
          if (last) begin
            grant0 = 1'b1;
          end else begin
            grant1 = 1'b1;
          end
        end else begin
          grant0 = r0_valid;
          grant1 = r1_valid;
        end
      end
      LOCK0: begin
        grant0 = r0_valid;
      end
      LOCK1: begin
        grant1 = r1_valid;
      end
      default: begin
        // Unreachable encoding: grant nothing; the state register recovers.
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Memory-side mux: granted requester's fields, all zeros when idle.
  always_comb begin
    mem_addr  = {DWIDTH{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DWIDTH{1'b0}};
    if (grant0) begin
      mem_addr  = r0_addr;
      mem_we    = r0_we;
      mem_wdata = r0_wdata;
    end else if (grant1) begin
      mem_addr  = r1_addr;
      mem_we    = r1_we;
      mem_wdata = r1_wdata;
    end else begin
      mem_addr  = {DWIDTH{1'b0}};
      mem_we    = 1'b0;
      mem_wdata = {DWIDTH{1'b0}};
    end
  end

  // Arbitration state, round-robin pointer and registered responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last         <= 1'b1;   // requester 0 wins the first tie
      r0_rsp_valid <= 1'b0;
      r0_rsp_rdata <= {DWIDTH{1'b0}};
      r1_rsp_valid <= 1'b0;
      r1_rsp_rdata <= {DWIDTH{1'b0}};
    end else begin
      // Responses are single-cycle pulses with no backpressure.
      r0_rsp_valid <= grant0;
      r1_rsp_valid <= grant1;

      if (grant0) begin
        r0_rsp_rdata <= r0_we ? {DWIDTH{1'b0}} : mem_rdata;
        last         <= 1'b0;
        state        <= r0_lock ? LOCK0 : IDLE;
      end else if (grant1) begin
        r1_rsp_rdata <= r1_we ? {DWIDTH{1'b0}} : mem_rdata;
        last         <= 1'b1;
        state        <= r1_lock ? LOCK1 : IDLE;
      end else begin
        // No transfer: a held lock persists (no timeout); an illegal
        // encoding falls back to IDLE.
        case (state)
          IDLE:    state <= IDLE;
          LOCK0:   state <= LOCK0;
          LOCK1:   state <= LOCK1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. Supplies a 16-word memory behind the
// DUT and keeps an independent reference model (lock owner, last-served
// requester, expected responses, shadow memory) computed from the arbitration
// rules. Directed scenarios come first, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rstn;
  logic        r0_valid, r0_ready, r0_we, r0_lock, r0_rsp_valid;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_lock, r1_rsp_valid;
  logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  // memory attached to the DUT
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];

  // reference model
  logic [31:0] ref_mem [16];
  int          owner;          // -1 = nobody holds the lock
  int          mlast;          // last granted requester
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];

  int checks;
  int failures;
  logic got0, got1;

  dmem_arbiter #(.DWIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wdata(r0_wdata), .r0_lock(r0_lock), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_rdata(r1_rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_r0(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [31:0] d);
    r0_valid = v; r0_we = we; r0_lock = lk; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set_r1(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [31:0] d);
    r1_valid = v; r1_we = we; r1_lock = lk; r1_addr = a; r1_wdata = d;
  endtask

  task automatic model_reset();
    owner = -1;
    mlast = 1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
  endtask

  // One clock cycle: inputs already driven just after a rising edge.
  task automatic step();
    int          g;
    logic [31:0] ea, ed;
    logic        ew;
    logic        w_en;
    logic [31:0] w_a, w_d;
    #2;
    g = -1;
    if (owner < 0) begin
      if (r0_valid && r1_valid) g = (mlast == 0) ? 1 : 0;
      else if (r0_valid)        g = 0;
      else if (r1_valid)        g = 1;
    end else if (owner == 0) begin
      if (r0_valid) g = 0;
    end else begin
      if (r1_valid) g = 1;
    end
    ea = (g == 0) ? r0_addr  : (g == 1) ? r1_addr  : 32'h0;
    ed = (g == 0) ? r0_wdata : (g == 1) ? r1_wdata : 32'h0;
    ew = (g == 0) ? r0_we    : (g == 1) ? r1_we    : 1'b0;

    chk("r0_ready",   {31'h0, r0_ready}, {31'h0, (g == 0)});
    chk("r1_ready",   {31'h0, r1_ready}, {31'h0, (g == 1)});
    chk("both_ready", {31'h0, r0_ready & r1_ready}, 32'h0);
    chk("mem_we",     {31'h0, mem_we}, {31'h0, ew});
    chk("mem_addr",   mem_addr, ea);
    chk("mem_wdata",  mem_wdata, ed);
    chk("r0_rsp_valid", {31'h0, r0_rsp_valid}, {31'h0, exp_rv[0]});
    chk("r1_rsp_valid", {31'h0, r1_rsp_valid}, {31'h0, exp_rv[1]});
    chk("r0_rsp_rdata", r0_rsp_rdata, exp_rd[0]);
    chk("r1_rsp_rdata", r1_rsp_rdata, exp_rd[1]);

    got0 = r0_ready;
    got1 = r1_ready;
    w_en = mem_we; w_a = mem_addr; w_d = mem_wdata;

    @(posedge clk);
    #1;
    if (w_en) mem[w_a[5:2]] = w_d;

    // reference model update for the transfer that just happened
    exp_rv[0] = (g == 0);
    exp_rv[1] = (g == 1);
    if (g >= 0) begin
      exp_rd[g] = ew ? 32'h0 : ref_mem[ea[5:2]];
      if (ew) ref_mem[ea[5:2]] = ed;
      owner = ((g == 0) ? r0_lock : r1_lock) ? g : -1;
      mlast = g;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1000_0000 + i * 32'h0101_0101;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    end
    set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r0_rsp_valid", {31'h0, r0_rsp_valid}, 32'h0);
    chk("rst_r1_rsp_valid", {31'h0, r1_rsp_valid}, 32'h0);
    chk("rst_r0_rsp_rdata", r0_rsp_rdata, 32'h0);
    chk("rst_r1_rsp_rdata", r1_rsp_rdata, 32'h0);
    rstn = 1'b1;

    // Both requesters read for 4 cycles: grants alternate r0, r1, r0, r1.
    for (int i = 0; i < 4; i++) begin
      set_r0(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i * 4), 32'h0);
      set_r1(1'b1, 1'b0, 1'b0, 32'h20 + 32'(i * 4), 32'h0);
      step();
      chk("alt_r0_grant", {31'h0, got0}, {31'h0, (i % 2 == 0)});
      chk("alt_r1_grant", {31'h0, got1}, {31'h0, (i % 2 == 1)});
    end

    // r1 writes DEADBEEF to 0x8, then r0 reads 0x8.
    set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_r1(1'b1, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF);
    step();
    set_r0(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wr_ack_rdata", r1_rsp_rdata, 32'h0);
    set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("raw_rdata", r0_rsp_rdata, 32'hDEADBEEF);

    // Only r1 valid for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      set_r1(1'b1, 1'b0, 1'b0, 32'h30 + 32'(i * 4), 32'h0);
      step();
      chk("solo_r1_grant", {31'h0, got1}, 32'h1);
      chk("solo_r0_ready", {31'h0, got0}, 32'h0);
    end

    // r0 locked read 0x4 then unlocking write 0x4, r1 waiting throughout.
    set_r0(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    set_r1(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
    step();
    chk("lock_r0_grant", {31'h0, got0}, 32'h1);
    chk("lock_r1_blocked", {31'h0, got1}, 32'h0);
    set_r0(1'b1, 1'b1, 1'b0, 32'h4, 32'h1234_5678);
    step();
    chk("unlock_r0_grant", {31'h0, got0}, 32'h1);
    chk("unlock_r1_blocked", {31'h0, got1}, 32'h0);
    set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("after_unlock_r1", {31'h0, got1}, 32'h1);

    // Reset while in LOCK1 with a response pending.
    set_r1(1'b1, 1'b0, 1'b1, 32'h3C, 32'h0);
    step();
    set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rstn = 1'b0;
    #1;
    chk("midrst_r1_rsp_valid", {31'h0, r1_rsp_valid}, 32'h0);
    chk("midrst_r0_rsp_valid", {31'h0, r0_rsp_valid}, 32'h0);
    chk("midrst_r1_rsp_rdata", r1_rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    set_r0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_r1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    step();
    chk("postrst_tie_r0", {31'h0, got0}, 32'h1);
    chk("postrst_tie_r1", {31'h0, got1}, 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 10000; i++) begin
      set_r0($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, 32'($urandom_range(0, 63)), $urandom);
      set_r1($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, 32'($urandom_range(0, 63)), $urandom);
      step();
    end
    set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing a single data memory (combinational read, write on clock edge) between the CPU load/store port (requester 0) and a loader/debug port (requester 1). It grants at most one access per cycle using round-robin priority and supports a lock for atomic read-modify-write sequences. Read data and acknowledges come back from registered responses one cycle after each grant. It sits between the CPU memory stage plus the debug loader and the data memory instance.

## Interface
- DWIDTH, 32, data and address width
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- r0_valid / r1_valid  input  1  requester has an access pending
- r0_ready / r1_ready  output  1  access granted this cycle (combinational)
- r0_addr / r1_addr  input  DWIDTH  byte address
- r0_we / r1_we  input  1  1 = write, 0 = read
- r0_wdata / r1_wdata  input  DWIDTH  write data
- r0_lock / r1_lock  input  1  keep the grant after this access
- r0_rsp_valid / r1_rsp_valid  output  1  one-cycle response pulse
- r0_rsp_rdata / r1_rsp_rdata  output  DWIDTH  read data, 0 for write acks
- mem_addr  output  DWIDTH  to memory address
- mem_we  output  1  to memory write enable
- mem_wdata  output  DWIDTH  to memory write data
- mem_rdata  input  DWIDTH  from memory, combinational read of mem_addr

## Operation
- State: IDLE, LOCK0, LOCK1. There is also a 1-bit `last` pointer holding the most recently granted requester.
- IDLE grant rule:
  - If only one requester has valid, that requester is granted.
  - If both have valid, the requester other than `last` is granted.
- LOCKn: only requester n can be granted. The other requester's ready stays 0 even when its valid is 1.
- A transfer happens in a cycle where valid and ready are both 1 for a requester. r0_ready and r1_ready are never 1 in the same cycle.
- Granted cycle:
  - mem_addr, mem_we and mem_wdata carry the granted requester's fields. mem_we = granted we.
  - For a read, mem_rdata is captured into that requester's rsp_rdata register.
  - For a write, 0 is captured into rsp_rdata.
  - That requester's rsp_valid is set for the next cycle.
- No grant: mem_we = 0. mem_addr and mem_wdata are 0.
- rsp_valid is a single-cycle pulse with no backpressure. The requester must accept it. rsp_rdata holds its value until the next response to that requester.
- Lock transitions, evaluated on each transfer by requester n:
  - lock = 1: next state is LOCKn.
  - lock = 0: next state is IDLE.
  - `last` is updated to n on every transfer.
- In LOCKn with valid_n = 0: the block stays in LOCKn. There is no timeout, and the requester is responsible for releasing the lock.
- Address bits [1:0] pass through unchanged. Alignment is the memory's concern.
- ready depends only on valid and the state. It never depends on lock, we or addr, so requesters cannot form a combinational loop through it.

## Timing
- Reset values:
  - state = IDLE, `last` = 1, so requester 0 wins the first tie.
  - rsp_valid = 0 and rsp_rdata = 0 for both requesters.
- Grant latency: 0 cycles. ready asserts in the same cycle as valid when the requester is eligible.
- Read latency: data appears on rsp_rdata with rsp_valid one cycle after the transfer cycle.
- Write: memory is updated at the transfer-cycle edge. A read by either requester in the next cycle returns the new data.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when the other requester is idle or the block is locked.
- Simultaneous transfer and lock release: the lock = 0 access itself completes, and arbitration in the following cycle uses the updated `last`.
- Reset mid-operation:
  - Pending responses are dropped (rsp_valid = 0) and any lock is cleared.
  - Memory contents are not affected by this block.

## Test plan
- Reset, then r0 and r1 both valid reads for 4 cycles:
  - Grants alternate r0, r1, r0, r1.
  - Each rsp_valid pulses exactly one cycle after its grant.
- r1 writes 0xDEADBEEF to 0x8, then r0 reads 0x8 in the next cycle:
  - r0_rsp_rdata = 0xDEADBEEF one cycle later.
  - r1_rsp_rdata = 0 for the write ack.
- r0 reads 0x4 with lock = 1 while r1_valid is held at 1, then r0 writes 0x4 with lock = 0:
  - r1_ready stays 0 for both r0 accesses.
  - r1 is granted in the cycle after the unlock.
- Only r1 is valid for 3 cycles: r1 is granted every cycle and r0_ready stays 0.
- Assert rstn low while in LOCK1 with a response pending:
  - rsp_valid outputs go to 0 immediately.
  - After release, a tie is granted to r0.
- Random valid/we/lock stimulus against a reference model for 10k cycles:
  - Never both ready in the same cycle.
  - mem_we is 0 when there is no grant.
  - All read data matches the model.
